// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size/exception encodings and FSM states for the data memory port
// Shared by mem_access_unit, load_extend and the exception unit.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] EXC_NONE  = 2'b00;
    localparam logic [1:0] EXC_HALF  = 2'b01;
    localparam logic [1:0] EXC_WORD  = 2'b10;
    localparam logic [1:0] EXC_FAULT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // Checks that never need the memory: alignment per size and the illegal size.
    function automatic logic [1:0] local_exc(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [1:0] exc;
        exc = EXC_NONE;
        case (size)
            SZ_HALF: if (addr_lo[0])          exc = EXC_HALF;
            SZ_WORD: if (addr_lo != 2'b00)    exc = EXC_WORD;
            SZ_BYTE: exc = EXC_NONE;
            default: exc = EXC_FAULT;
        endcase
        return exc;
    endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - aligns big-endian load data and sign/zero-extends it
// Ports: size (access size), sign_ext (sign-extend), r_data (raw memory data), rdata (extended result).
module load_extend
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] r_data,
    output logic [31:0] rdata
);

    // The memory is big-endian: the addressed byte always sits in [31:24].
    always_comb begin
        rdata = r_data;
        case (size)
            SZ_BYTE: rdata = {{24{sign_ext & r_data[31]}}, r_data[31:24]};
            SZ_HALF: rdata = {{16{sign_ext & r_data[31]}}, r_data[31:16]};
            default: rdata = r_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store initiator for the data memory port
// Ports:
//   CLK, RST_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_store/size/signed/addr/wdata request fields, sampled at the handshake only
//   resp_valid/resp_rdata/resp_exc  one-cycle response with extended data and exception code
//   Addr/MemRd/MemWr/Type/W_data    memory command side
//   R_data/Mem_busy/MemWrong        memory response side
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_exc,
    output logic [31:0] Addr,
    output logic        MemRd,
    output logic        MemWr,
    output logic [1:0]  Type,
    output logic [31:0] W_data,
    input  logic [31:0] R_data,
    input  logic        Mem_busy,
    input  logic [1:0]  MemWrong
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state;
    state_t        state_nx;
    logic          signed_q;
    logic          store_q;
    logic [CW-1:0] cnt;
    logic [1:0]    req_exc;
    logic [31:0]   ext_data;
    logic          timed_out;

    // Addr/Type/W_data double as the request latch; they stay put until the next accept.
    load_extend u_load_extend (
        .size     (Type),
        .sign_ext (signed_q),
        .r_data   (R_data),
        .rdata    (ext_data)
    );

    assign req_ready = (state == ST_IDLE);
    assign req_exc   = local_exc(req_size, req_addr[1:0]);
    assign timed_out = (cnt == CW'(TIMEOUT));

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (req_valid) state_nx = (req_exc != EXC_NONE) ? ST_RESP : ST_ISSUE;
            ST_ISSUE: state_nx = ST_WAIT;
            ST_WAIT:  if (!Mem_busy || timed_out) state_nx = ST_RESP;
            ST_RESP:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state      <= ST_IDLE;
            signed_q   <= 1'b0;
            store_q    <= 1'b0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_exc   <= EXC_NONE;
            Addr       <= '0;
            MemRd      <= 1'b0;
            MemWr      <= 1'b0;
            Type       <= SZ_BYTE;
            W_data     <= '0;
        end else begin
            state      <= state_nx;
            MemRd      <= 1'b0;
            MemWr      <= 1'b0;
            resp_valid <= (state_nx == ST_RESP);
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        Addr     <= req_addr;
                        Type     <= req_size;
                        W_data   <= req_wdata;
                        signed_q <= req_signed;
                        store_q  <= req_store;
                        if (req_exc != EXC_NONE) begin
                            resp_exc   <= req_exc;
                            resp_rdata <= '0;
                        end else begin
                            MemRd <= ~req_store;
                            MemWr <= req_store;
                        end
                    end
                end
                ST_ISSUE: cnt <= '0;
                ST_WAIT: begin
                    // A completion in the same cycle the limit is hit still counts as success.
                    if (!Mem_busy) begin
                        resp_exc   <= MemWrong;
                        resp_rdata <= (store_q || MemWrong != EXC_NONE) ? 32'h0 : ext_data;
                    end else if (timed_out) begin
                        resp_exc   <= EXC_FAULT;
                        resp_rdata <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_exc;
    logic [31:0] Addr;
    logic        MemRd;
    logic        MemWr;
    logic [1:0]  Type;
    logic [31:0] W_data;
    logic [31:0] R_data = '0;
    logic        Mem_busy = 1'b0;
    logic [1:0]  MemWrong = 2'b00;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_unit #(.TIMEOUT(16)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_exc   (resp_exc),
        .Addr       (Addr),
        .MemRd      (MemRd),
        .MemWr      (MemWr),
        .Type       (Type),
        .W_data     (W_data),
        .R_data     (R_data),
        .Mem_busy   (Mem_busy),
        .MemWrong   (MemWrong)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Presents one request before edge 0, scrambles the request fields afterwards,
    // drives Mem_busy high for WAIT cycles 2..2+busy_n-1 and observes cycles 1..40.
    task automatic access(input string tag, input logic store, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rmem, input logic [1:0] mw, input int busy_n,
                          input logic issues, input logic [31:0] exp_rdata,
                          input logic [1:0] exp_exc, input int exp_cycle);
        int rd_cnt = 0, wr_cnt = 0, strobe_cyc = -1, resp_cyc = -1, pulses = 0;
        logic [31:0] addr_at = '0, wdata_at = '0, rdata_at = '0;
        logic [1:0]  type_at = '0, exc_at = '0;
        logic        ready_in_resp = 1'b1, ready_after = 1'b0;
        R_data   = rmem;
        MemWrong = mw;
        req_store = store; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        check({tag, " ready_idle"}, req_ready, 1);
        @(posedge CLK);
        #1;
        req_valid = 1'b0; req_store = ~store; req_size = 2'b11;
        req_signed = ~sgn; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            Mem_busy = (c >= 2) && (c < 2 + busy_n);
            if (MemRd) rd_cnt++;
            if (MemWr) wr_cnt++;
            if ((MemRd || MemWr) && strobe_cyc < 0) begin
                strobe_cyc = c; addr_at = Addr; type_at = Type; wdata_at = W_data;
            end
            if (resp_valid) begin
                pulses++;
                if (resp_cyc < 0) begin
                    resp_cyc = c; rdata_at = resp_rdata; exc_at = resp_exc;
                    ready_in_resp = req_ready;
                end
            end
            if (resp_cyc > 0 && c == resp_cyc + 1) begin
                ready_after = req_ready;
                break;
            end
        end
        Mem_busy = 1'b0;
        check({tag, " resp_cycle"}, resp_cyc, exp_cycle);
        check({tag, " rdata"}, rdata_at, exp_rdata);
        check({tag, " exc"}, exc_at, exp_exc);
        check({tag, " pulses"}, pulses, 1);
        check({tag, " ready_resp"}, ready_in_resp, 0);
        check({tag, " ready_after"}, ready_after, 1);
        check({tag, " rd_count"}, rd_cnt, (issues && !store) ? 1 : 0);
        check({tag, " wr_count"}, wr_cnt, (issues && store) ? 1 : 0);
        if (issues) begin
            check({tag, " strobe_cycle"}, strobe_cyc, 1);
            check({tag, " addr"}, addr_at, addr);
            check({tag, " type"}, type_at, size);
            if (store) check({tag, " wdata"}, wdata_at, wdata);
        end
    endtask

    initial begin
        int pulses;
        repeat (3) @(negedge CLK);
        check("rst req_ready", req_ready, 1);
        check("rst resp_valid", resp_valid, 0);
        check("rst resp_rdata", resp_rdata, 0);
        check("rst resp_exc", resp_exc, 0);
        check("rst Addr", Addr, 0);
        check("rst MemRd", MemRd, 0);
        check("rst MemWr", MemWr, 0);
        check("rst Type", Type, 0);
        check("rst W_data", W_data, 0);
        RST_n = 1'b1;
        @(negedge CLK);

        //     tag        st    size   sg    addr          wdata         R_data        MW     busy iss  exp_rdata     exc    cyc
        access("lw",      1'b0, 2'b10, 1'b0, 32'h0000_0180, 32'h0,        32'h4200_0000, 2'b00, 0, 1'b1, 32'h4200_0000, 2'b00, 3);
        access("lb_s",    1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0,        32'h8012_3456, 2'b00, 0, 1'b1, 32'hFFFF_FF80, 2'b00, 3);
        access("lb_u",    1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0,        32'h8012_3456, 2'b00, 0, 1'b1, 32'h0000_0080, 2'b00, 3);
        access("lh_s",    1'b0, 2'b01, 1'b1, 32'h0000_0010, 32'h0,        32'h8001_ABCD, 2'b00, 0, 1'b1, 32'hFFFF_8001, 2'b00, 3);
        access("lh_u",    1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0,        32'h8001_ABCD, 2'b00, 0, 1'b1, 32'h0000_8001, 2'b00, 3);
        access("lw_sgn",  1'b0, 2'b10, 1'b1, 32'h0000_0020, 32'h0,        32'h8765_4321, 2'b00, 0, 1'b1, 32'h8765_4321, 2'b00, 3);
        access("sh_mis",  1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h1234,     32'h0,         2'b00, 0, 1'b0, 32'h0,         2'b01, 1);
        access("lw_mis",  1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'h0,        32'hFFFF_FFFF, 2'b00, 0, 1'b0, 32'h0,         2'b10, 1);
        access("ill_sz",  1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0,        32'hFFFF_FFFF, 2'b00, 0, 1'b0, 32'h0,         2'b11, 1);
        access("sw_tmo",  1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,        2'b00, 20, 1'b1, 32'h0,        2'b11, 19);
        access("sw_bsy3", 1'b1, 2'b10, 1'b0, 32'h0000_0304, 32'h0BAD_BEEF, 32'h1111_1111, 2'b00, 3, 1'b1, 32'h0,        2'b00, 6);
        access("lh_mw",   1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0,        32'h8234_5678, 2'b01, 0, 1'b1, 32'h0,         2'b01, 3);
        access("lb_bsy1", 1'b0, 2'b00, 1'b0, 32'h0000_0007, 32'h0,        32'h7F00_0000, 2'b00, 1, 1'b1, 32'h0000_007F, 2'b00, 4);

        // Reset during WAIT aborts the access with no response.
        R_data = 32'h1234_5678; MemWrong = 2'b00;
        req_store = 1'b0; req_size = 2'b10; req_signed = 1'b0;
        req_addr = 32'h0000_0040; req_valid = 1'b1;
        @(posedge CLK);
        #1 req_valid = 1'b0;
        Mem_busy = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("rstw addr_before", Addr, 32'h0000_0040);
        check("rstw ready_before", req_ready, 0);
        #2 RST_n = 1'b0;
        #1;
        check("rstw Addr", Addr, 0);
        check("rstw Type", Type, 0);
        check("rstw MemRd", MemRd, 0);
        check("rstw ready", req_ready, 1);
        @(negedge CLK);
        RST_n = 1'b1;
        Mem_busy = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge CLK);
            if (resp_valid) pulses++;
        end
        check("rstw no_resp", pulses, 0);
        access("after_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0044, 32'h0, 32'h0102_0304, 2'b00, 0, 1'b1, 32'h0102_0304, 2'b00, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
